// File: rtl/pcr_clock_counter_if.sv
// rtl/pcr_clock_counter_if.sv - load and snapshot handshake bundle for the PCR time base
interface pcr_clock_counter_if #(
    parameter int BASE_WIDTH = 33,
    parameter int EXT_WIDTH  = 9
);
    logic                  load_valid;
    logic [BASE_WIDTH-1:0] load_base;
    logic [EXT_WIDTH-1:0]  load_ext;
    logic                  load_err;
    logic                  snap_req;
    logic                  snap_overrun;
    logic                  pcr_valid;
    logic                  pcr_ready;
    logic [BASE_WIDTH-1:0] pcr_base;
    logic [EXT_WIDTH-1:0]  pcr_ext;
    logic                  pcr_disc;

    modport master (
        input  load_valid, load_base, load_ext, snap_req, pcr_ready,
        output load_err, snap_overrun, pcr_valid, pcr_base, pcr_ext, pcr_disc
    );

    modport slave (
        output load_valid, load_base, load_ext, snap_req, pcr_ready,
        input  load_err, snap_overrun, pcr_valid, pcr_base, pcr_ext, pcr_disc
    );
endinterface

// File: rtl/pcr_clock_counter.sv
// rtl/pcr_clock_counter.sv - 27 MHz driven PCR base/extension counter with snapshot handshake
module pcr_clock_counter #(
    parameter int BASE_WIDTH = 33,
    parameter int EXT_MODULO = 300,
    parameter int EXT_WIDTH  = 9
) (
    input  logic                  clk2,
    input  logic                  rstn,
    input  logic                  clk_27m_in,
    input  logic                  en,
    pcr_clock_counter_if.master   bus,
    output logic [BASE_WIDTH-1:0] cur_base,
    output logic [EXT_WIDTH-1:0]  cur_ext
);
    localparam logic [EXT_WIDTH-1:0] EXT_MAX = EXT_WIDTH'(EXT_MODULO - 1);

    typedef enum logic {IDLE, HOLD} snap_state_t;

    snap_state_t state_q, state_d;
    logic        clk_27m_q;
    logic        tick;
    logic        load_ok;
    logic        load_bad;
    logic        disc_pending;
    logic        capture;
    logic        overrun_d;

    assign tick     = clk_27m_in & ~clk_27m_q & en;
    assign load_ok  = bus.load_valid && (bus.load_ext <= EXT_MAX);
    assign load_bad = bus.load_valid && (bus.load_ext > EXT_MAX);

    // Any load strobe, accepted or rejected, swallows a coincident tick.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            clk_27m_q    <= 1'b0;
            cur_base     <= '0;
            cur_ext      <= '0;
            disc_pending <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            clk_27m_q    <= clk_27m_in;
            bus.load_err <= load_bad;
            if (load_ok) begin
                cur_base <= bus.load_base;
                cur_ext  <= bus.load_ext;
            end else if (!bus.load_valid && tick) begin
                if (cur_ext == EXT_MAX) begin
                    cur_ext  <= '0;
                    cur_base <= cur_base + BASE_WIDTH'(1);
                end else begin
                    cur_ext  <= cur_ext + EXT_WIDTH'(1);
                end
            end
            if (load_ok) begin
                disc_pending <= 1'b1;
            end else if (capture) begin
                disc_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.snap_req) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.pcr_ready) begin
                    if (bus.snap_req) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.snap_req) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            bus.pcr_base     <= '0;
            bus.pcr_ext      <= '0;
            bus.pcr_disc     <= 1'b0;
            bus.snap_overrun <= 1'b0;
        end else begin
            state_q          <= state_d;
            bus.snap_overrun <= overrun_d;
            if (capture) begin
                bus.pcr_base <= cur_base;
                bus.pcr_ext  <= cur_ext;
                bus.pcr_disc <= disc_pending;
            end
        end
    end

    assign bus.pcr_valid = (state_q == HOLD);
endmodule

// File: tb/tb_pcr_clock_counter.sv
// tb/tb_pcr_clock_counter.sv - randomized and directed bench for pcr_clock_counter
module tb_pcr_clock_counter;
    localparam longint unsigned MODV = 64'd8589934592 * 64'd300;

    logic        clk2 = 1'b0;
    logic        rstn;
    logic        clk_27m_in;
    logic        en;
    logic [32:0] cur_base;
    logic [8:0]  cur_ext;

    pcr_clock_counter_if #(.BASE_WIDTH(33), .EXT_WIDTH(9)) bus ();

    pcr_clock_counter #(.BASE_WIDTH(33), .EXT_MODULO(300), .EXT_WIDTH(9)) dut (
        .clk2       (clk2),
        .rstn       (rstn),
        .clk_27m_in (clk_27m_in),
        .en         (en),
        .bus        (bus),
        .cur_base   (cur_base),
        .cur_ext    (cur_ext)
    );

    always #5 clk2 = ~clk2;

    int total = 0;
    int bad   = 0;
    int wph   = 0;

    // reference model: the whole PCR as one count of 27 MHz ticks
    longint unsigned m_total;
    logic            m_prev27;
    logic            m_disc_pend;
    logic            m_hold;
    longint unsigned m_pb;
    longint unsigned m_pe;
    logic            m_pdisc;
    logic            m_lerr;
    logic            m_ovr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total = 0; m_prev27 = 1'b0; m_disc_pend = 1'b0; m_hold = 1'b0;
        m_pb = 0; m_pe = 0; m_pdisc = 1'b0; m_lerr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_edge();
        logic            tk;
        logic            cap;
        longint unsigned cb;
        longint unsigned ce;
        tk       = clk_27m_in & ~m_prev27 & en;
        m_prev27 = clk_27m_in;
        cb       = m_total / 300;
        ce       = m_total % 300;
        cap      = 1'b0;
        m_lerr   = 1'b0;
        m_ovr    = 1'b0;
        if (!m_hold) begin
            cap = bus.snap_req;
        end else if (bus.pcr_ready) begin
            if (bus.snap_req) cap = 1'b1;
            else m_hold = 1'b0;
        end else if (bus.snap_req) begin
            m_ovr = 1'b1;
        end
        if (cap) begin
            m_pb = cb; m_pe = ce; m_pdisc = m_disc_pend;
            m_hold = 1'b1; m_disc_pend = 1'b0;
        end
        if (bus.load_valid) begin
            if (bus.load_ext < 300) begin
                m_total     = longint'(bus.load_base) * 300 + longint'(bus.load_ext);
                m_disc_pend = 1'b1;
            end else begin
                m_lerr = 1'b1;
            end
        end else if (tk) begin
            m_total = (m_total + 1) % MODV;
        end
    endtask

    task automatic compare_all();
        chk("cur_base", 64'(cur_base), m_total / 300);
        chk("cur_ext", 64'(cur_ext), m_total % 300);
        chk("pcr_valid", 64'(bus.pcr_valid), 64'(m_hold));
        chk("pcr_base", 64'(bus.pcr_base), m_pb);
        chk("pcr_ext", 64'(bus.pcr_ext), m_pe);
        chk("pcr_disc", 64'(bus.pcr_disc), 64'(m_pdisc));
        chk("load_err", 64'(bus.load_err), 64'(m_lerr));
        chk("snap_overrun", 64'(bus.snap_overrun), 64'(m_ovr));
    endtask

    // One clk2 cycle: present the wave phase, model the edge, compare at negedge.
    task automatic cycle();
        clk_27m_in = ((wph % 4) >= 2);
        wph++;
        @(posedge clk2);
        if (!rstn) model_reset();
        else model_edge();
        @(negedge clk2);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [32:0] b, input logic [8:0] e);
        bus.load_valid = 1'b1; bus.load_base = b; bus.load_ext = e;
        cycle();
        bus.load_valid = 1'b0;
    endtask

    task automatic strobe(input logic sr, input logic rdy);
        bus.snap_req = sr; bus.pcr_ready = rdy;
        cycle();
        bus.snap_req = 1'b0; bus.pcr_ready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; clk_27m_in = 1'b0;
        bus.load_valid = 1'b0; bus.load_base = '0; bus.load_ext = '0;
        bus.snap_req = 1'b0; bus.pcr_ready = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk2);
        rstn = 1'b1;

        // 1200 cycles = 300 ticks -> one full extension period
        run(1200);
        chk("wrap300_base", 64'(cur_base), 64'd1);
        chk("wrap300_ext", 64'(cur_ext), 64'd0);
        run(4);
        chk("tick301_ext", 64'(cur_ext), 64'd1);

        do_load(33'h1_FFFF_FFFF, 9'd299);
        run(4);
        chk("basewrap_base", 64'(cur_base), 64'd0);
        chk("basewrap_ext", 64'(cur_ext), 64'd0);

        while ((wph % 4) != 2) cycle();
        do_load(33'd100, 9'd5);
        chk("load_tick_base", 64'(cur_base), 64'd100);
        chk("load_tick_ext", 64'(cur_ext), 64'd5);
        en = 1'b0;
        do_load(33'd7, 9'd300);
        chk("load_err_pulse", 64'(bus.load_err), 64'd1);
        chk("load_err_ext", 64'(cur_ext), 64'd5);
        cycle();
        chk("load_err_single", 64'(bus.load_err), 64'd0);
        en = 1'b1;

        // overrun while holding
        strobe(1'b1, 1'b0);
        run(2);
        strobe(1'b1, 1'b0);
        chk("overrun_pulse", 64'(bus.snap_overrun), 64'd1);
        run(7);
        strobe(1'b0, 1'b1);
        chk("valid_fall", 64'(bus.pcr_valid), 64'd0);

        // discontinuity flag and back-to-back capture
        do_load(33'd4242, 9'd17);
        strobe(1'b1, 1'b0);
        chk("disc_set", 64'(bus.pcr_disc), 64'd1);
        strobe(1'b1, 1'b1);
        chk("b2b_valid", 64'(bus.pcr_valid), 64'd1);
        chk("disc_clear", 64'(bus.pcr_disc), 64'd0);
        strobe(1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en            = ($urandom_range(0, 9) != 0);
            bus.snap_req  = ($urandom_range(0, 9) < 3);
            bus.pcr_ready = ($urandom_range(0, 1) == 1);
            bus.load_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.load_base = 33'h1_FFFF_FFFF - 33'($urandom_range(0, 2));
            else
                bus.load_base = {1'($urandom()), 32'($urandom())};
            bus.load_ext = 9'($urandom_range(0, 311));
            if ($urandom_range(0, 19) == 0) wph++;
            cycle();
        end
        bus.load_valid = 1'b0; bus.snap_req = 1'b0; bus.pcr_ready = 1'b1;
        cycle();
        bus.pcr_ready = 1'b0;

        // async reset while a snapshot is held
        en = 1'b0;
        do_load(33'd77, 9'd150);
        strobe(1'b1, 1'b0);
        chk("hold_ext", 64'(bus.pcr_ext), 64'd150);
        chk("hold_valid", 64'(bus.pcr_valid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_valid", 64'(bus.pcr_valid), 64'd0);
        run(2);
        rstn = 1'b1;

        // en low freezes the counters while the wave keeps running
        en = 1'b1;
        do_load(33'd5, 9'd7);
        en = 1'b0;
        run(40);
        chk("frozen_base", 64'(cur_base), 64'd5);
        chk("frozen_ext", 64'(cur_ext), 64'd7);
        en = 1'b1;
        run(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
